// File: rtl/bk_pkg.sv
// Shared Brent-Kung helpers: prefix operator, width log, result flag bundle.
package bk_pkg;

  typedef struct packed {
    logic cout;
    logic ovf;
    logic zero;
  } flags_t;

  // (G,P) o (G',P'): hi span absorbs the lower span it sits on top of
  function automatic logic [1:0] pg_combine(input logic g_hi, input logic p_hi,
                                            input logic g_lo, input logic p_lo);
    return {g_hi | (p_hi & g_lo), p_hi & p_lo};
  endfunction

  function automatic int log2w(input int w);
    int r;
    r = 0;
    for (int i = 0; i < 16; i++)
      if ((1 << i) < w) r = i + 1;
    return r;
  endfunction

endpackage

// File: rtl/bk_prefix_tree.sv
// Combinational Brent-Kung carry network: up-sweep then down-sweep, then fold in cin.
module bk_prefix_tree
  import bk_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] p,
  input  logic [WIDTH-1:0] g,
  input  logic             cin,
  output logic [WIDTH:0]   c
);

  localparam int L    = log2w(WIDTH);
  localparam int NLVL = 2 * L - 1;

  genvar lv;
  generate
    for (lv = 0; lv <= NLVL; lv++) begin : g_lvl
      logic [WIDTH-1:0] go, po;
      if (lv == 0) begin : g_leaf
        assign go = g;
        assign po = p;
      end else begin : g_node
        // levels 1..L are the up-sweep (span 2^lv), the rest walk the span back down
        localparam int  SPAN = (lv <= L) ? (1 << lv) : (1 << (2 * L - lv));
        localparam int  HALF = SPAN / 2;
        localparam bit  UP   = (lv <= L);
        logic [WIDTH-1:0] gi, pin;
        assign gi  = g_lvl[lv-1].go;
        assign pin = g_lvl[lv-1].po;
        always_comb begin
          go = gi;
          po = pin;
          for (int k = 0; k < WIDTH; k++) begin
            if (k >= HALF) begin
              if (UP ? (((k + 1) % SPAN) == 0)
                     : ((((k + 1) % SPAN) == HALF) && (k >= SPAN)))
                {go[k], po[k]} = pg_combine(gi[k], pin[k], gi[k-HALF], pin[k-HALF]);
            end
          end
        end
      end
    end
  endgenerate

  logic [WIDTH-1:0] gf, pf;
  assign gf = g_lvl[NLVL].go;
  assign pf = g_lvl[NLVL].po;

  always_comb begin
    c    = '0;
    c[0] = cin;
    for (int i = 0; i < WIDTH; i++)
      c[i+1] = gf[i] | (pf[i] & cin);
  end

endmodule

// File: rtl/bk_adder_pipe.sv
// Two-stage elastic Brent-Kung adder/subtractor with valid/ready on both sides.
module bk_adder_pipe
  import bk_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  input  logic             in_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf,
  output logic             out_zero
);

  logic             s1_valid;
  logic [WIDTH-1:0] s1_p, s1_g;
  logic             s1_cin, s1_amsb, s1_bmsb;
  logic [WIDTH-1:0] b_eff;
  logic             in_fire, s2_load;

  assign b_eff    = in_sub ? ~in_b : in_b;
  assign s2_load  = s1_valid & (~out_valid | out_ready);
  assign in_ready = ~s1_valid | s2_load;
  assign in_fire  = in_valid & in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_p     <= '0;
      s1_g     <= '0;
      s1_cin   <= 1'b0;
      s1_amsb  <= 1'b0;
      s1_bmsb  <= 1'b0;
    end else if (in_fire) begin
      s1_valid <= 1'b1;
      s1_p     <= in_a ^ b_eff;
      s1_g     <= in_a & b_eff;
      s1_cin   <= in_cin;
      s1_amsb  <= in_a[WIDTH-1];
      s1_bmsb  <= b_eff[WIDTH-1];
    end else if (s2_load) begin
      s1_valid <= 1'b0;
    end
  end

  logic [WIDTH:0]   c;
  logic [WIDTH-1:0] sum;
  flags_t           flags, out_flags;

  bk_prefix_tree #(.WIDTH(WIDTH)) u_tree (
    .p  (s1_p),
    .g  (s1_g),
    .cin(s1_cin),
    .c  (c)
  );

  assign sum        = s1_p ^ c[WIDTH-1:0];
  assign flags.cout = c[WIDTH];
  assign flags.ovf  = (s1_amsb == s1_bmsb) && (sum[WIDTH-1] != s1_amsb);
  assign flags.zero = ~|sum;

  // a new result may overwrite the one leaving this edge, keeping out_valid high
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_flags <= '0;
    end else if (s2_load) begin
      out_valid <= 1'b1;
      out_sum   <= sum;
      out_flags <= flags;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  assign out_cout = out_flags.cout;
  assign out_ovf  = out_flags.ovf;
  assign out_zero = out_flags.zero;

endmodule

// File: doc/bk_adder_pipe.md
Name: bk_adder_pipe

Overview:
- Parametrised, pipelined Brent-Kung prefix adder/subtractor with valid/ready handshakes on both sides.
- Next generation of the team's fixed 16-bit combinational Brent-Kung adder. Adds:
  - generic power-of-two width;
  - add/subtract mode;
  - status flags (carry, signed overflow, zero);
  - a two-stage elastic pipeline that sustains one operation per cycle under backpressure.
- Sits in the datapath between operand sources and accumulator or ALU result consumers.

Parameters:
- WIDTH, 32, operand/result width. Power of two, 4..128. Prefix tree depth is 2*log2(WIDTH)-1 levels.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  block can accept a beat this cycle.
- in_a  in  WIDTH  operand A.
- in_b  in  WIDTH  operand B.
- in_cin  in  1  carry-in. Set it to 1 for plain subtraction.
- in_sub  in  1  0 = a+b+cin, 1 = a+~b+cin.
- out_valid  out  1  result beat valid.
- out_ready  in  1  consumer accepts result.
- out_sum  out  WIDTH  result.
- out_cout  out  1  carry-out of the MSB. In subtract mode, 1 = no borrow.
- out_ovf  out  1  two's-complement overflow.
- out_zero  out  1  out_sum == 0.

Behaviour:
- Reset (rst_n low, asynchronous): both stage valid bits clear. out_valid=0, out_sum=0, out_cout=0, out_ovf=0, out_zero=0. in_ready reads 1 from the first cycle after release.
- Handshakes:
  - Input transfer: in_valid && in_ready at a rising edge.
  - Output transfer: out_valid && out_ready at a rising edge.
  - Payload must hold stable while valid is high and ready is low (source obligation). The block must not drop or duplicate a beat.
- Stage 1 register, loaded on input transfer, holds:
  - bitwise p = a ^ b', g = a & b', where b' = in_sub ? ~in_b : in_b;
  - cin, a[WIDTH-1], b'[WIDTH-1].
- Stage 2 (output register) holds the full Brent-Kung prefix result from stage-1 contents:
  - up-sweep: group (G,P) at spans 2,4,...,WIDTH;
  - down-sweep: fills the remaining carries;
  - carry into bit i: c[i] = G[i-1:0] | (P[i-1:0] & cin);
  - sum[i] = p[i] ^ c[i];
  - cout = c[WIDTH];
  - ovf = (a_msb == b'_msb) && (sum_msb != a_msb);
  - zero = ~|sum.
- Latency: exactly 2 cycles from input transfer to out_valid when out_ready is held high.
- Throughput: 1 beat/cycle.
- Flow control:
  - s2_load = s1_valid && (!out_valid || out_ready)
  - in_ready = !s1_valid || s2_load
  - in_ready is combinational from out_ready (no registered skid). This is acceptable at this width.
- Backpressure: with out_ready low and both stages full, in_ready=0 and both stages hold their contents unchanged.
- Simultaneous output transfer and s2_load: the new result replaces the old in the same edge, and out_valid stays 1.
- Simultaneous output transfer, empty stage 1, and input transfer: out_valid drops to 0 for one cycle, then the new beat appears.
- Result bits are pure modulo-2^WIDTH arithmetic. No saturation.
- Reset asserted mid-operation: all in-flight beats are discarded, with no partial output.

Decomposition:
- Package bk_pkg:
  - function pg_combine: (G,P) o (G',P') = (G | P&G', P&P');
  - localparam LOG2W helper function;
  - typedef of the flag bundle {cout, ovf, zero}.
- Sub-module bk_prefix_tree, parameter WIDTH:
  - purely combinational;
  - inputs p, g, cin; output carries c[WIDTH:0];
  - generate-loop up-sweep and down-sweep.
- bk_adder_pipe contains only the operand conditioning, the two stage registers and the handshake logic.

Test Plan:
- WIDTH=16, single beat a=16'hFFFF, b=16'h0001, cin=0, add, out_ready=1 -> 2 cycles later sum=16'h0000, cout=1, ovf=0, zero=1.
- WIDTH=16, subtract a=16'h8000, b=16'h0001, cin=1 -> sum=16'h7FFF, cout=1, ovf=1, zero=0. Then a=16'h0003, b=16'h0005, cin=1 -> sum=16'hFFFE, cout=0, ovf=0.
- WIDTH=32, back-to-back stream of 100 random beats, in_valid and out_ready held 1 -> one result per cycle, in order. Each result matches a+b(+cin) mod 2^32, and flags match a reference model.
- WIDTH=32, out_ready low for 5 cycles with in_valid held 1 -> in_ready falls after 2 beats are accepted. out_sum is stable throughout. On release, the results drain in order with no loss or duplication.
- WIDTH=32, rst_n pulsed low asynchronously while 2 beats are in flight -> out_valid=0 and all outputs are 0 immediately. The first post-reset beat returns with 2-cycle latency.
- WIDTH=4 and WIDTH=128 elaborations, exhaustive sweep (WIDTH=4: all 512 combinations of a, b, cin in add and subtract mode) -> zero mismatches against a behavioural model.
